// File: rtl/rv_wb_bridge.sv
// Memory-stage to Wishbone classic bridge: one transaction at a time through
// IDLE -> BUS -> RESP, with a bus-wait timeout that reports as an error.
module rv_wb_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_sel,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_rdata,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_stb,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    input  logic        i_wb_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic [31:0] rdata_q, rdata_d;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (i_req) begin
                    // An all-zero byte select has nothing to transfer: complete without a bus cycle.
                    if (i_sel != 4'd0) begin
                        adr_d   = i_addr;
                        dat_d   = i_wdata;
                        sel_d   = i_sel;
                        we_d    = i_we;
                        cnt_d   = '0;
                        state_d = S_BUS;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_RESP;
                    end
                end
            end
            S_BUS: begin
                if (i_wb_err) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else if (i_wb_ack) begin
                    if (!we_q) begin
                        rdata_d = i_wb_dat;
                    end
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_busy   = (state_q != S_IDLE);
    assign o_done   = (state_q == S_RESP);
    assign o_err    = (state_q == S_RESP) && err_q;
    assign o_rdata  = rdata_q;
    assign o_wb_cyc = (state_q == S_BUS);
    assign o_wb_stb = (state_q == S_BUS);
    assign o_wb_we  = (state_q == S_BUS) && we_q;
    assign o_wb_adr = adr_q;
    assign o_wb_dat = dat_q;
    assign o_wb_sel = sel_q;

endmodule

// File: tb/tb_rv_wb_bridge.sv
// Scoreboard bench for rv_wb_bridge: each completion is matched against the
// {err, rdata} pushed when the request was driven; timing checked per scenario.
module tb_rv_wb_bridge;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_stb;
    logic        wb_cyc;
    logic [31:0] wb_dat_i;
    logic        wb_ack;
    logic        wb_err;

    int checks = 0;
    int errors = 0;
    logic [32:0] sb_q[$];
    logic [31:0] exp_rdata;

    rv_wb_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .i_req    (req),
        .i_we     (we),
        .i_addr   (addr),
        .i_wdata  (wdata),
        .i_sel    (sel),
        .o_busy   (busy),
        .o_done   (done),
        .o_err    (err),
        .o_rdata  (rdata),
        .o_wb_adr (wb_adr),
        .o_wb_dat (wb_dat_o),
        .o_wb_sel (wb_sel),
        .o_wb_we  (wb_we),
        .o_wb_stb (wb_stb),
        .o_wb_cyc (wb_cyc),
        .i_wb_dat (wb_dat_i),
        .i_wb_ack (wb_ack),
        .i_wb_err (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Completion monitor: every o_done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && done) begin
            logic [32:0] exp;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_done: got err=%0b rdata=%h, required no completion", err, rdata);
            end else begin
                exp = sb_q.pop_front();
                if ({err, rdata} !== exp) begin
                    errors++;
                    $display("FAIL sb_result: got err=%0b rdata=%h, required err=%0b rdata=%h",
                             err, rdata, exp[32], exp[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req = 1'b1; we = w; addr = a; wdata = d; sel = s;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; req = 0; we = 0; addr = 0; wdata = 0; sel = 0;
        wb_dat_i = 0; wb_ack = 0; wb_err = 0;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, wb_cyc, wb_stb, wb_we, rdata, wb_adr, wb_dat_o, wb_sel} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%0b done=%0b err=%0b cyc=%0b rdata=%h adr=%h dat=%h sel=%h, required all 0",
                     busy, done, err, wb_cyc, rdata, wb_adr, wb_dat_o, wb_sel);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_rdata = 32'h0;
    endtask

    task automatic test_read_zero_wait();
        @(negedge clk);
        start_req(1'b0, 32'h1000_0004, 32'h0, 4'hF);
        exp_rdata = 32'hDEAD_BEEF;
        sb_q.push_back({1'b0, exp_rdata});
        @(negedge clk);
        req = 0;
        checks++;
        if ({wb_cyc, wb_stb, wb_we, wb_adr, wb_sel} !== {3'b110, 32'h1000_0004, 4'hF}) begin
            errors++;
            $display("FAIL read_bus: got cyc=%0b stb=%0b we=%0b adr=%h sel=%h, required 1 1 0 10000004 f",
                     wb_cyc, wb_stb, wb_we, wb_adr, wb_sel);
        end
        wb_ack = 1; wb_dat_i = 32'hDEAD_BEEF;
        @(negedge clk);
        wb_ack = 0;
        checks++;
        if ({done, busy, wb_cyc} !== 3'b110) begin
            errors++;
            $display("FAIL read_done_cycle2: got done=%0b busy=%0b cyc=%0b, required 1 1 0", done, busy, wb_cyc);
        end
        @(negedge clk);
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL read_idle_after: got done=%0b busy=%0b, required 0 0", done, busy);
        end
    endtask

    task automatic test_write_wait3();
        @(negedge clk);
        start_req(1'b1, 32'h2000_0008, 32'h1234_5678, 4'h3);
        sb_q.push_back({1'b0, exp_rdata});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            req = 0;
            checks++;
            if ({wb_cyc, wb_stb, wb_we, wb_dat_o, wb_sel, done} !== {3'b111, 32'h1234_5678, 4'h3, 1'b0}) begin
                errors++;
                $display("FAIL write_bus_cycle%0d: got cyc=%0b stb=%0b we=%0b dat=%h sel=%h done=%0b, required 1 1 1 12345678 3 0",
                         i + 1, wb_cyc, wb_stb, wb_we, wb_dat_o, wb_sel, done);
            end
            if (i == 3) begin
                wb_ack = 1; wb_dat_i = 32'hBAD0_BAD0;
            end
        end
        @(negedge clk);
        wb_ack = 0;
        checks++;
        if ({done, err, wb_cyc} !== 3'b100) begin
            errors++;
            $display("FAIL write_done_cycle5: got done=%0b err=%0b cyc=%0b, required 1 0 0", done, err, wb_cyc);
        end
        @(negedge clk);
        checks++;
        if ({wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o, wb_sel} !== {3'b000, 32'h2000_0008, 32'h1234_5678, 4'h3}) begin
            errors++;
            $display("FAIL write_idle_hold: got cyc=%0b stb=%0b we=%0b adr=%h dat=%h sel=%h, required 0 0 0 20000008 12345678 3",
                     wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o, wb_sel);
        end
    endtask

    task automatic test_ack_err();
        @(negedge clk);
        start_req(1'b0, 32'h0000_0100, 32'h0, 4'hF);
        sb_q.push_back({1'b1, exp_rdata});
        @(negedge clk);
        req = 0;
        wb_ack = 1; wb_err = 1; wb_dat_i = 32'h5555_5555;
        @(negedge clk);
        wb_ack = 0; wb_err = 0;
        checks++;
        if ({done, err} !== 2'b11) begin
            errors++;
            $display("FAIL ack_err_done: got done=%0b err=%0b, required 1 1", done, err);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int n;
        @(negedge clk);
        start_req(1'b0, 32'h0000_0200, 32'h0, 4'hF);
        wb_dat_i = 32'h7777_7777;
        sb_q.push_back({1'b1, exp_rdata});
        @(negedge clk);
        req = 0;
        n = 0;
        while (wb_cyc === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL timeout_cyc_len: got %0d cycles, required 4", n);
        end
        checks++;
        if ({done, err} !== 2'b11) begin
            errors++;
            $display("FAIL timeout_done: got done=%0b err=%0b, required 1 1", done, err);
        end
        @(negedge clk);
    endtask

    task automatic test_sel_zero();
        @(negedge clk);
        start_req(1'b0, 32'h6000_0000, 32'h0, 4'h0);
        sb_q.push_back({1'b0, exp_rdata});
        @(negedge clk);
        checks++;
        if ({done, err, wb_cyc} !== 3'b100) begin
            errors++;
            $display("FAIL sel0_done_cycle1: got done=%0b err=%0b cyc=%0b, required 1 0 0", done, err, wb_cyc);
        end
        start_req(1'b1, 32'hAAAA_0000, 32'h1111_1111, 4'hF);
        @(negedge clk);
        req = 0;
        checks++;
        if ({busy, wb_cyc, wb_adr} !== {2'b00, 32'h0000_0200}) begin
            errors++;
            $display("FAIL sel0_req_in_resp_ignored: got busy=%0b cyc=%0b adr=%h, required 0 0 00000200", busy, wb_cyc, wb_adr);
        end
    endtask

    task automatic test_busy_ignore();
        @(negedge clk);
        start_req(1'b0, 32'h4000_0010, 32'h0, 4'hF);
        @(negedge clk);
        start_req(1'b1, 32'h5555_0000, 32'h9999_9999, 4'h1);
        @(negedge clk);
        req = 0;
        checks++;
        if ({wb_adr, wb_sel, wb_we, wb_cyc} !== {32'h4000_0010, 4'hF, 2'b01}) begin
            errors++;
            $display("FAIL busy_req_ignored: got adr=%h sel=%h we=%0b cyc=%0b, required 40000010 f 0 1", wb_adr, wb_sel, wb_we, wb_cyc);
        end
        wb_ack = 1; wb_dat_i = 32'h1357_9BDF;
        exp_rdata = 32'h1357_9BDF;
        sb_q.push_back({1'b0, exp_rdata});
        @(negedge clk);
        wb_ack = 0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL busy_done: got done=%0b, required 1", done);
        end
        @(negedge clk);
        checks++;
        if ({busy, wb_cyc, wb_adr} !== {2'b00, 32'h4000_0010}) begin
            errors++;
            $display("FAIL busy_no_second_txn: got busy=%0b cyc=%0b adr=%h, required 0 0 40000010", busy, wb_cyc, wb_adr);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        start_req(1'b0, 32'h0000_0300, 32'h0, 4'hF);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL b2b_idle_%0d: got busy=%0b, required 0", k, busy);
            end
            @(negedge clk);
            checks++;
            if (wb_cyc !== 1'b1) begin
                errors++;
                $display("FAIL b2b_bus_%0d: got cyc=%0b, required 1", k, wb_cyc);
            end
            wb_ack = 1; wb_dat_i = 32'hC0FF_EE00 + 32'(k);
            exp_rdata = wb_dat_i;
            sb_q.push_back({1'b0, exp_rdata});
            @(negedge clk);
            wb_ack = 0;
            checks++;
            if (done !== 1'b1) begin
                errors++;
                $display("FAIL b2b_done_%0d: got done=%0b, required 1", k, done);
            end
            if (k == 2) req = 0;
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end_idle: got busy=%0b, required 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start_req(1'b0, 32'h0000_0400, 32'h0, 4'hF);
        @(negedge clk);
        req = 0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({wb_cyc, wb_stb, busy, done} !== 4'b0000) begin
            errors++;
            $display("FAIL rst_async_drop: got cyc=%0b stb=%0b busy=%0b done=%0b, required 0 0 0 0", wb_cyc, wb_stb, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wb_ack = 1; wb_dat_i = 32'hFFFF_0000;
        exp_rdata = 32'h0;
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_rdata_clear: got %h, required 00000000", rdata);
        end
        @(negedge clk);
        wb_ack = 0;
        checks++;
        if ({done, busy, wb_cyc, rdata} !== {3'b000, 32'h0}) begin
            errors++;
            $display("FAIL rst_late_ack_ignored: got done=%0b busy=%0b cyc=%0b rdata=%h, required 0 0 0 00000000",
                     done, busy, wb_cyc, rdata);
        end
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        start_req(1'b0, 32'h3000_0000, 32'h0, 4'hF);
        @(negedge clk);
        req = 0;
        checks++;
        if ({wb_cyc, wb_adr} !== {1'b1, 32'h3000_0000}) begin
            errors++;
            $display("FAIL rst_first_req_accepted: got cyc=%0b adr=%h, required 1 30000000", wb_cyc, wb_adr);
        end
        wb_ack = 1; wb_dat_i = 32'h0BAD_F00D;
        exp_rdata = 32'h0BAD_F00D;
        sb_q.push_back({1'b0, exp_rdata});
        @(negedge clk);
        wb_ack = 0;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL rst_post_done: got done=%0b, required 1", done);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_wait3();
        test_ack_err();
        test_timeout();
        test_sel_zero();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending completions, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
